// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared state encoding, stream routing and error bit indices
package waveform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wf_state_t;

  localparam logic [3:0] TDEST_WAVEFORM = 4'h2;

  localparam int ERR_BAD_LEN = 0;
  localparam int ERR_SHORT   = 1;
  localparam int ERR_LONG    = 2;
  localparam int ERR_TIMEOUT = 3;

  // A length is usable when it is non-zero and fits in a RAM of 2^aw words.
  function automatic logic len_ok(input logic [31:0] len, input int aw);
    logic [32:0] depth;
    depth = 33'd1 << aw;
    return (len != 32'd0) && ({1'b0, len} <= depth);
  endfunction

endpackage

// File: rtl/wf_watchdog.sv
// rtl/wf_watchdog.sv - idle-cycle watchdog between accepted stream beats
module wf_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds the idle cycles already elapsed; the cycle seeing LIMIT is the last allowed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || kick) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = !load && !kick && (cnt == LIMIT);

endmodule

// File: rtl/waveform_ram_writer.sv
// rtl/waveform_ram_writer.sv - loads a streamed waveform into the external sample RAM
module waveform_ram_writer
  import waveform_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic                  axi_tclk,
  input  logic                  axi_treset,
  input  logic                  init_wf_write,
  input  logic [127:0]          waveform_parameters,
  output logic                  wf_write_ready,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [3:0]            s_axis_tkeep,
  input  logic [3:0]            s_axis_tdest,
  input  logic [3:0]            s_axis_tid,
  input  logic [31:0]           s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_we,
  output logic [31:0]           wf_length,
  output logic                  wf_valid,
  output logic                  wf_done,
  output logic [3:0]            wf_error
);

  wf_state_t             state, state_next;
  logic [31:0]           len;
  logic [ADDR_WIDTH-1:0] count;
  logic                  accept, wr_beat, last_word, expire, new_len_ok;
  logic [3:0]            err_set;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep, s_axis_tid, s_axis_tuser, waveform_parameters[127:32]};

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign last_word  = (32'(count) == (len - 32'd1));
  assign new_len_ok = len_ok(waveform_parameters[31:0], ADDR_WIDTH);

  wf_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (axi_tclk),
    .rst    (axi_treset),
    .load   (state == ST_IDLE),
    .kick   (accept),
    .expire (expire)
  );

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    wf_done       = 1'b0;
    wr_beat       = 1'b0;
    err_set       = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (init_wf_write && new_len_ok) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        s_axis_tready = 1'b1;
        if (expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = ST_IDLE;
        end else if (accept && (s_axis_tdest == TDEST_WAVEFORM)) begin
          wr_beat = 1'b1;
          if (last_word && s_axis_tlast) begin
            state_next = ST_DONE;
          end else if (last_word) begin
            err_set[ERR_LONG] = 1'b1;
            state_next        = ST_DRAIN;
          end else if (s_axis_tlast) begin
            err_set[ERR_SHORT] = 1'b1;
            state_next         = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        s_axis_tready = 1'b1;
        if (expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_next           = ST_IDLE;
        end else if (accept && s_axis_tlast) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        wf_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      len            <= '0;
      count          <= '0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      wf_length      <= '0;
      wf_valid       <= 1'b0;
      wf_error       <= '0;
      wf_write_ready <= 1'b0;
    end else begin
      ram_we         <= 1'b0;
      wf_write_ready <= (state_next == ST_IDLE);
      if (wr_beat) begin
        ram_we    <= 1'b1;
        ram_addr  <= count;
        ram_wdata <= s_axis_tdata;
        count     <= count + 1'b1;
      end
      if (state == ST_IDLE) begin
        if (init_wf_write) begin
          len <= waveform_parameters[31:0];
          if (new_len_ok) begin
            wf_error <= '0;
            wf_valid <= 1'b0;
            count    <= '0;
          end else begin
            wf_error <= 4'b0001 << ERR_BAD_LEN;
          end
        end
      end else begin
        wf_error <= wf_error | err_set;
      end
      if (state == ST_DONE) begin
        wf_length <= len;
        wf_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_waveform_ram_writer.sv
// tb/tb_waveform_ram_writer.sv - directed self-checking bench for waveform_ram_writer
module tb_waveform_ram_writer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_wf_write = 1'b0;
  logic [127:0]  waveform_parameters = '0;
  logic          wf_write_ready;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [3:0]    s_axis_tkeep = 4'hF;
  logic [3:0]    s_axis_tdest = 4'h2;
  logic [3:0]    s_axis_tid = 4'h5;
  logic [31:0]   s_axis_tuser = 32'h1234_5678;
  logic          s_axis_tready;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic [31:0]   wf_length;
  logic          wf_valid;
  logic          wf_done;
  logic [3:0]    wf_error;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  always #5 clk = ~clk;

  waveform_ram_writer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .axi_tclk            (clk),
    .axi_treset          (rst),
    .init_wf_write       (init_wf_write),
    .waveform_parameters (waveform_parameters),
    .wf_write_ready      (wf_write_ready),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tdest        (s_axis_tdest),
    .s_axis_tid          (s_axis_tid),
    .s_axis_tuser        (s_axis_tuser),
    .s_axis_tready       (s_axis_tready),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_we              (ram_we),
    .wf_length           (wf_length),
    .wf_valid            (wf_valid),
    .wf_done             (wf_done),
    .wf_error            (wf_error)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
    end
    if (wf_done) done_cnt++;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !wf_write_ready; i++) @(negedge clk);
    total++;
    if (wf_write_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: got %b want 1", wf_write_ready);
    end
  endtask

  task automatic start_wf(input logic [31:0] len);
    wait_ready();
    init_wf_write = 1'b1;
    waveform_parameters = {96'hDEAD_BEEF_CAFE_F00D_0BAD_F00D, len};
    @(posedge clk);
    @(negedge clk);
    init_wf_write = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] dest, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tdest  = dest;
    s_axis_tlast  = last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stop_stream();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdest  = 4'h2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wf_write_ready, s_axis_tready, ram_we, wf_valid, wf_done, wf_error, wf_length} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b trdy=%b we=%b val=%b done=%b err=%b len=%0d want all 0",
               wf_write_ready, s_axis_tready, ram_we, wf_valid, wf_done, wf_error, wf_length);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wf_write_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", wf_write_ready);
    end
  endtask

  task automatic test_normal();
    clear_log();
    start_wf(32'd8);
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + i, 4'h2, i == 7);
    stop_stream();
    repeat (3) @(negedge clk);
    total++;
    if (log_addr.size() != 8) begin
      bad++;
      $display("FAIL normal_writes: got %0d want 8", log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (log_addr[i] !== AW'(i) || log_data[i] !== 32'hA000_0000 + i) begin
          bad++;
          $display("FAIL normal_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   i, log_addr[i], log_data[i], i, 32'hA000_0000 + i);
        end
      end
    end
    total++;
    if (done_cnt != 1 || wf_length !== 32'd8 || wf_valid !== 1'b1 || wf_error !== 4'b0000 || wf_write_ready !== 1'b1) begin
      bad++;
      $display("FAIL normal_commit: got done=%0d len=%0d val=%b err=%b rdy=%b want 1 8 1 0000 1",
               done_cnt, wf_length, wf_valid, wf_error, wf_write_ready);
    end
  endtask

  task automatic test_short();
    clear_log();
    start_wf(32'd8);
    for (int i = 0; i < 5; i++) send(32'hB000_0000 + i, 4'h2, i == 4);
    stop_stream();
    repeat (3) @(negedge clk);
    total++;
    if (wf_error !== 4'b0010 || done_cnt != 0 || wf_valid !== 1'b0 || wf_write_ready !== 1'b1 || s_axis_tready !== 1'b0) begin
      bad++;
      $display("FAIL short: got err=%b done=%0d val=%b rdy=%b trdy=%b want 0010 0 0 1 0",
               wf_error, done_cnt, wf_valid, wf_write_ready, s_axis_tready);
    end
    total++;
    if (log_addr.size() != 5) begin
      bad++;
      $display("FAIL short_writes: got %0d want 5", log_addr.size());
    end
  endtask

  task automatic test_long();
    clear_log();
    start_wf(32'd4);
    for (int i = 0; i < 6; i++) send(32'hC000_0000 + i, 4'h2, i == 5);
    stop_stream();
    repeat (3) @(negedge clk);
    total++;
    if (log_addr.size() != 4 || log_addr[3] !== AW'(3) || log_data[3] !== 32'hC000_0003) begin
      bad++;
      $display("FAIL long_writes: got n=%0d want 4 ending addr 3 data c0000003", log_addr.size());
    end
    total++;
    if (wf_error !== 4'b0100 || done_cnt != 1 || wf_valid !== 1'b1 || wf_length !== 32'd4) begin
      bad++;
      $display("FAIL long_commit: got err=%b done=%0d val=%b len=%0d want 0100 1 1 4",
               wf_error, done_cnt, wf_valid, wf_length);
    end
  endtask

  task automatic test_bad_len();
    logic [31:0] lens [2];
    lens[0] = 32'd0;
    lens[1] = 32'd17;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      start_wf(lens[k]);
      repeat (3) @(negedge clk);
      total++;
      if (wf_error !== 4'b0001 || wf_write_ready !== 1'b1 || s_axis_tready !== 1'b0 || log_addr.size() != 0) begin
        bad++;
        $display("FAIL bad_len_%0d: got err=%b rdy=%b trdy=%b writes=%0d want 0001 1 0 0",
                 lens[k], wf_error, wf_write_ready, s_axis_tready, log_addr.size());
      end
      total++;
      if (wf_valid !== 1'b1 || wf_length !== 32'd4) begin
        bad++;
        $display("FAIL bad_len_keep_%0d: got val=%b len=%0d want 1 4", lens[k], wf_valid, wf_length);
      end
    end
  endtask

  task automatic test_full_depth();
    clear_log();
    start_wf(32'd16);
    for (int i = 0; i < 16; i++) send(32'hD000_0000 + i, 4'h2, i == 15);
    stop_stream();
    repeat (3) @(negedge clk);
    total++;
    if (log_addr.size() != 16 || log_addr[15] !== AW'(15) || log_data[15] !== 32'hD000_000F) begin
      bad++;
      $display("FAIL full_depth_writes: got n=%0d want 16 ending addr 15", log_addr.size());
    end
    total++;
    if (wf_length !== 32'd16 || wf_error !== 4'b0000 || done_cnt != 1) begin
      bad++;
      $display("FAIL full_depth_commit: got len=%0d err=%b done=%0d want 16 0000 1", wf_length, wf_error, done_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    start_wf(32'd8);
    for (int i = 0; i < 3; i++) send(32'hE000_0000 + i, 4'h2, 1'b0);
    stop_stream();
    repeat (15) @(negedge clk);
    total++;
    if (s_axis_tready !== 1'b1 || wf_error !== 4'b0000) begin
      bad++;
      $display("FAIL timeout_early: got trdy=%b err=%b want 1 0000", s_axis_tready, wf_error);
    end
    @(negedge clk);
    total++;
    if (wf_error !== 4'b1000 || s_axis_tready !== 1'b0 || wf_valid !== 1'b0 || wf_write_ready !== 1'b1 || done_cnt != 0) begin
      bad++;
      $display("FAIL timeout: got err=%b trdy=%b val=%b rdy=%b done=%0d want 1000 0 0 1 0",
               wf_error, s_axis_tready, wf_valid, wf_write_ready, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    start_wf(32'd2);
    send(32'h1111_0000, 4'h2, 1'b0);
    send(32'h1111_0001, 4'h2, 1'b1);
    stop_stream();
    start_wf(32'd2);
    send(32'h2222_0000, 4'h2, 1'b0);
    send(32'h2222_0001, 4'h2, 1'b1);
    stop_stream();
    repeat (3) @(negedge clk);
    total++;
    if (log_addr.size() != 4 || log_addr[2] !== AW'(0) || log_data[2] !== 32'h2222_0000 ||
        log_addr[3] !== AW'(1) || log_data[3] !== 32'h2222_0001) begin
      bad++;
      $display("FAIL b2b_writes: got n=%0d want 4 with second run at addr 0,1", log_addr.size());
    end
    total++;
    if (done_cnt != 2 || wf_length !== 32'd2 || wf_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_commit: got done=%0d len=%0d val=%b want 2 2 1", done_cnt, wf_length, wf_valid);
    end
  endtask

  task automatic test_tdest_reset();
    clear_log();
    start_wf(32'd8);
    send(32'h3300_0000, 4'h2, 1'b0);
    send(32'hBAD0_0000, 4'h3, 1'b0);
    send(32'h3300_0001, 4'h2, 1'b0);
    send(32'hBAD0_0001, 4'h3, 1'b1);
    send(32'h3300_0002, 4'h2, 1'b0);
    stop_stream();
    @(negedge clk);
    total++;
    if (log_addr.size() != 3 || log_data[1] !== 32'h3300_0001 || log_addr[2] !== AW'(2) || log_data[2] !== 32'h3300_0002) begin
      bad++;
      $display("FAIL tdest_filter: got n=%0d want 3 tdest=2 words at addr 0..2", log_addr.size());
    end
    total++;
    if (s_axis_tready !== 1'b1 || wf_error !== 4'b0000) begin
      bad++;
      $display("FAIL tdest_still_writing: got trdy=%b err=%b want 1 0000", s_axis_tready, wf_error);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({wf_write_ready, s_axis_tready, ram_we, wf_valid, wf_done, wf_error, wf_length} !== '0) begin
      bad++;
      $display("FAIL midwrite_reset: got rdy=%b trdy=%b we=%b val=%b done=%b err=%b len=%0d want all 0",
               wf_write_ready, s_axis_tready, ram_we, wf_valid, wf_done, wf_error, wf_length);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wf_write_ready !== 1'b1 || s_axis_tready !== 1'b0 || wf_length !== 32'd0 || wf_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: got rdy=%b trdy=%b len=%0d val=%b want 1 0 0 0",
               wf_write_ready, s_axis_tready, wf_length, wf_valid);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short();
    test_long();
    test_bad_len();
    test_full_depth();
    test_timeout();
    test_back_to_back();
    test_tdest_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/waveform_ram_writer.md
WAVEFORM_RAM_WRITER -- requirements
Module: waveform_ram_writer

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 14, as the waveform RAM word-address width (depth 2^ADDR_WIDTH words).
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 1048575, as the maximum idle cycles between beats in WRITE.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; ports axi_tclk and axi_treset are fixed.
REQ-004 Port axi_tclk, input, 1 -- sole clock.
REQ-005 Port axi_treset, input, 1 -- async active-high reset.
REQ-006 Port init_wf_write, input, 1 -- request to load a new waveform; held high until wf_write_ready is seen.
REQ-007 Port waveform_parameters, input, 128 -- [31:0] waveform length in 32-bit words; [127:32] ignored.
REQ-008 Port wf_write_ready, output, 1 -- writer idle and able to accept init_wf_write.
REQ-009 Ports s_axis_tdata in 32, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_tkeep in 4, s_axis_tdest in 4, s_axis_tid in 4, s_axis_tuser in 32, s_axis_tready out 1 -- formatted waveform sample stream.
REQ-010 Ports ram_addr out ADDR_WIDTH, ram_wdata out 32, ram_we out 1 -- simple-dual-port RAM write side.
REQ-011 Port wf_length, output, 32 -- length of the last committed waveform.
REQ-012 Port wf_valid, output, 1 -- a complete waveform is stored and may be played.
REQ-013 Port wf_done, output, 1 -- one-cycle pulse on commit.
REQ-014 Port wf_error, output, 4 -- sticky flags: [0] bad length, [1] short (early tlast), [2] long (overrun), [3] timeout.

Function
REQ-015 States SHALL be IDLE, WRITE, DRAIN, DONE.
REQ-016 IDLE: wf_write_ready=1 (registered), s_axis_tready=0; on init_wf_write=1, len=waveform_parameters[31:0] SHALL be captured and wf_error cleared.
REQ-017 If len==0 or len>2^ADDR_WIDTH, wf_error[0] SHALL be set and the state SHALL stay IDLE; wf_valid unchanged.
REQ-018 Otherwise the next state SHALL be WRITE, with wf_valid<=0, word count<=0, wf_write_ready<=0 on the same edge.
REQ-019 WRITE: s_axis_tready=1; a beat is accepted when s_axis_tvalid & s_axis_tready.
REQ-020 Accepted beats with s_axis_tdest!=4'h2 SHALL be dropped: no RAM write, no count change.
REQ-021 For each accepted tdest==2 beat, the next cycle SHALL present ram_we=1, ram_addr=count, ram_wdata=s_axis_tdata (1-cycle latency); count then increments.
REQ-022 The beat with count==len-1 and tlast=1 SHALL go to DONE.
REQ-023 A tlast beat with count<len-1 SHALL set wf_error[1] and return to IDLE without commit; already-written words are left in RAM.
REQ-024 The beat with count==len-1 and tlast=0 SHALL set wf_error[2] and go to DRAIN.
REQ-025 DRAIN: s_axis_tready=1, all beats dropped; on the accepted tlast beat go to DONE. Overrun waveform is still committed.
REQ-026 A watchdog SHALL count cycles with no accepted beat in WRITE/DRAIN; at TIMEOUT_CYCLES it SHALL set wf_error[3] and return to IDLE without commit.
REQ-027 DONE (one cycle): wf_length<=len, wf_valid<=1, wf_done=1, then IDLE.
REQ-028 init_wf_write outside IDLE SHALL be ignored.
REQ-029 ram_addr SHALL never exceed len-1; no wrap is possible.
REQ-030 s_axis_tkeep, s_axis_tid and s_axis_tuser SHALL be ignored.

Reset
REQ-031 On axi_treset assertion, at any time including mid-WRITE: state=IDLE, all outputs 0 except wf_write_ready=1 after the first clock, wf_valid=0, wf_length=0, wf_error=0, ram_we=0.

Structure
REQ-032 Shared package waveform_pkg SHALL hold the state encoding, TDEST_WAVEFORM=4'h2, and the wf_error bit indices.
REQ-033 The watchdog SHALL be sub-module wf_watchdog (load, kick, expire); the RAM is external.

Verification
REQ-034 init with len=8, 8 beats tdest=2, tlast on the 8th -> ram_we at addrs 0..7 with matching data, wf_done pulse, wf_length=8, wf_valid=1, wf_error=0.
REQ-035 len=8, tlast on the 5th beat -> wf_error=4'b0010, no wf_done, wf_valid=0, back in IDLE (wf_write_ready=1).
REQ-036 len=4, 6 beats, tlast on the 6th -> 4 writes only, wf_error=4'b0100, wf_done, wf_valid=1, wf_length=4.
REQ-037 len=0 and len=2^ADDR_WIDTH+1 -> wf_error=4'b0001, stays IDLE, no ram_we.
REQ-038 TIMEOUT_CYCLES=16, len=8, 3 beats then tvalid=0 for 16 cycles -> wf_error=4'b1000, IDLE, wf_valid=0.
REQ-039 Interleaved tdest=3 beats plus axi_treset asserted mid-WRITE -> tdest=3 beats not written; after reset, state IDLE, all outputs at reset values.
